// File: rtl/ibex_pkg.sv
// ibex_pkg: shared types for the register-file write scheduler.
// Holds the scheduler FSM state encoding and the write-request record
// used when talking about a single register-file write.
package ibex_pkg;

    // Width of the data field in the write-request record.
    localparam int unsigned RfWreqDataWidth = 32;

    // Scheduler states: zeroing sweep after reset, then normal arbitration.
    typedef enum logic {
        RF_WS_INIT = 1'b0,
        RF_WS_RUN  = 1'b1
    } rf_wsched_state_e;

    // One register-file write: destination and data.
    typedef struct packed {
        logic [4:0]                 waddr;
        logic [RfWreqDataWidth-1:0] wdata;
    } rf_wreq_t;

endpackage

// File: rtl/ibex_rr_arb2.sv
// ibex_rr_arb2: two-requester round-robin arbiter.
// Ports:
//   clk_int   - clock
//   rst_ni    - asynchronous active-low reset (pointer prefers requester 0)
//   req_i     - request vector, bit 0 and bit 1
//   gnt_o     - one-hot (or zero) grant vector, combinational from req_i
//   advance_i - allow the pointer to move on a contended grant this cycle
module ibex_rr_arb2 (
    input  logic       clk_int,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    input  logic       advance_i
);

    // ptr_q = 0 means requester 0 wins a tie, 1 means requester 1 wins.
    logic ptr_q;
    logic ptr_d;

    // A lone requester always wins; only a tie consults the pointer.
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = ptr_q ? 2'b10 : 2'b01;
        end
    end

    // After a tie the pointer moves to the loser, so it wins the next tie.
    // Uncontended grants leave the pointer alone.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (&req_i)) begin
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ibex_rf_write_sched.sv
// ibex_rf_write_sched: write-port scheduler for the single-write-port
// latch-based register file. After reset it optionally zeroes every
// register (x1 upwards), then shares the port between EX and LSU with
// round-robin arbitration, issuing one registered write per cycle.
// Ports:
//   clk_int, rst_ni            - clock, asynchronous active-low reset
//   ex_valid_i/ex_ready_o      - EX writeback handshake
//   ex_waddr_i/ex_wdata_i      - EX destination and data
//   lsu_valid_i/lsu_ready_o    - LSU writeback handshake
//   lsu_waddr_i/lsu_wdata_i    - LSU destination and data
//   init_done_o                - sweep finished, scheduler in RUN
//   rf_we_o/rf_waddr_o/rf_wdata_o - registered write to the register file
module ibex_rf_write_sched
    import ibex_pkg::*;
#(
    parameter bit                    RV32E       = 1'b0,
    parameter int unsigned           DataWidth   = 32,
    parameter bit                    InitSweep   = 1'b1,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0
) (
    input  logic                 clk_int,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 init_done_o,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o
);

    localparam int unsigned AddrWidth = RV32E ? 4 : 5;
    localparam int unsigned NumWords  = 2 ** AddrWidth;
    // The counter carries one extra bit so that reaching NumWords marks
    // "last register already issued" and costs one idle cycle before RUN.
    localparam logic [AddrWidth:0] CntDone = (AddrWidth + 1)'(NumWords);
    localparam logic [AddrWidth:0] CntOne  = (AddrWidth + 1)'(1);
    localparam rf_wsched_state_e ResetState = InitSweep ? RF_WS_INIT : RF_WS_RUN;

    rf_wsched_state_e     state_q, state_d;
    logic [AddrWidth:0]   cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;

    logic                 run;
    logic [1:0]           arb_req;
    logic [1:0]           arb_gnt;
    logic [4:0]           sel_waddr;
    logic [DataWidth-1:0] sel_wdata;

    assign run     = (state_q == RF_WS_RUN);
    // Requests are masked outside RUN so neither side sees ready during the sweep.
    assign arb_req = run ? {lsu_valid_i, ex_valid_i} : 2'b00;

    ibex_rr_arb2 u_arb (
        .clk_int   (clk_int),
        .rst_ni    (rst_ni),
        .req_i     (arb_req),
        .gnt_o     (arb_gnt),
        .advance_i (run)
    );

    assign ex_ready_o  = arb_gnt[0];
    assign lsu_ready_o = arb_gnt[1];
    assign sel_waddr   = arb_gnt[1] ? lsu_waddr_i : ex_waddr_i;
    assign sel_wdata   = arb_gnt[1] ? lsu_wdata_i : ex_wdata_i;

    // Next-state and next-write logic. Address/data hold unless a real
    // write is issued; writes to x0 (low address bits zero) are accepted
    // but produce no register-file write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            RF_WS_INIT: begin
                if (cnt_q == CntDone) begin
                    state_d = RF_WS_RUN;
                end else begin
                    we_d    = 1'b1;
                    waddr_d = 5'(cnt_q[AddrWidth-1:0]);
                    wdata_d = WordZeroVal;
                    cnt_d   = cnt_q + CntOne;
                end
            end
            RF_WS_RUN: begin
                if ((|arb_gnt) && (sel_waddr[AddrWidth-1:0] != '0)) begin
                    we_d    = 1'b1;
                    waddr_d = 5'(sel_waddr[AddrWidth-1:0]);
                    wdata_d = sel_wdata;
                end
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    always_ff @(posedge clk_int or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ResetState;
            cnt_q   <= CntOne;
            we_q    <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= WordZeroVal;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign init_done_o = run;
    assign rf_we_o     = we_q;
    assign rf_waddr_o  = waddr_q;
    assign rf_wdata_o  = wdata_q;

`ifndef SYNTHESIS
    a_one_ready : assert property (@(posedge clk_int) disable iff (!rst_ni)
        !(ex_ready_o && lsu_ready_o));
    a_no_ready_init : assert property (@(posedge clk_int) disable iff (!rst_ni)
        (state_q == RF_WS_INIT) |-> !(ex_ready_o || lsu_ready_o));
    a_ex_stable : assert property (@(posedge clk_int) disable iff (!rst_ni)
        (ex_valid_i && !ex_ready_o) |=>
            (ex_valid_i && $stable(ex_waddr_i) && $stable(ex_wdata_i)));
    a_lsu_stable : assert property (@(posedge clk_int) disable iff (!rst_ni)
        (lsu_valid_i && !lsu_ready_o) |=>
            (lsu_valid_i && $stable(lsu_waddr_i) && $stable(lsu_wdata_i)));
`endif

endmodule

// File: tb/tb_ibex_rf_write_sched.sv
// Directed self-checking bench for ibex_rf_write_sched: one RV32I instance
// and one RV32E instance sharing clock and reset.
module tb_ibex_rf_write_sched;

    logic        clkInt;
    logic        rstN;

    logic        exValid, lsuValid, exReady, lsuReady;
    logic [4:0]  exWaddr, lsuWaddr, rfWaddr;
    logic [31:0] exWdata, lsuWdata, rfWdata;
    logic        initDone, rfWe;

    logic        eExValid, eLsuValid, eExReady, eLsuReady;
    logic [4:0]  eExWaddr, eLsuWaddr, eRfWaddr;
    logic [31:0] eExWdata, eLsuWdata, eRfWdata;
    logic        eInitDone, eRfWe;

    int testCount = 0;
    int failCount = 0;

    ibex_rf_write_sched #(.RV32E(1'b0)) dut (
        .clk_int     (clkInt),
        .rst_ni      (rstN),
        .ex_valid_i  (exValid),
        .ex_ready_o  (exReady),
        .ex_waddr_i  (exWaddr),
        .ex_wdata_i  (exWdata),
        .lsu_valid_i (lsuValid),
        .lsu_ready_o (lsuReady),
        .lsu_waddr_i (lsuWaddr),
        .lsu_wdata_i (lsuWdata),
        .init_done_o (initDone),
        .rf_we_o     (rfWe),
        .rf_waddr_o  (rfWaddr),
        .rf_wdata_o  (rfWdata)
    );

    ibex_rf_write_sched #(.RV32E(1'b1)) dutE (
        .clk_int     (clkInt),
        .rst_ni      (rstN),
        .ex_valid_i  (eExValid),
        .ex_ready_o  (eExReady),
        .ex_waddr_i  (eExWaddr),
        .ex_wdata_i  (eExWdata),
        .lsu_valid_i (eLsuValid),
        .lsu_ready_o (eLsuReady),
        .lsu_waddr_i (eLsuWaddr),
        .lsu_wdata_i (eLsuWdata),
        .init_done_o (eInitDone),
        .rf_we_o     (eRfWe),
        .rf_waddr_o  (eRfWaddr),
        .rf_wdata_o  (eRfWdata)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clkInt = 1'b0;
        forever #5 clkInt = ~clkInt;
    end

    // Advance to just after the next rising edge, where registered outputs are sampled.
    task automatic tick();
        @(posedge clkInt);
        #1;
    endtask

    // Reset values, then the full sweep on both instances.
    task automatic test_reset();
        logic [4:0] expAddr;
        rstN = 1'b0;
        exValid = 0; exWaddr = 0; exWdata = 0;
        lsuValid = 0; lsuWaddr = 0; lsuWdata = 0;
        eExValid = 0; eExWaddr = 0; eExWdata = 0;
        eLsuValid = 0; eLsuWaddr = 0; eLsuWdata = 0;
        tick();
        tick();
        testCount++;
        if ({rfWe, rfWaddr, rfWdata, initDone, exReady, lsuReady} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0}) begin
            $display("[TB] FAIL reset_state: we=%b waddr=%0d wdata=%h done=%b rdy=%b%b, required all zero",
                     rfWe, rfWaddr, rfWdata, initDone, exReady, lsuReady);
            failCount++;
        end
        rstN = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            expAddr = 5'(k);
            testCount++;
            if (rfWe !== 1'b1 || rfWaddr !== expAddr || rfWdata !== 32'd0 || initDone !== 1'b0) begin
                $display("[TB] FAIL sweep_%0d: we=%b waddr=%0d wdata=%h done=%b, required 1/%0d/0/0",
                         k, rfWe, rfWaddr, rfWdata, initDone, expAddr);
                failCount++;
            end
            if (k <= 15) begin
                testCount++;
                if (eRfWe !== 1'b1 || eRfWaddr !== expAddr || eInitDone !== 1'b0) begin
                    $display("[TB] FAIL e_sweep_%0d: we=%b waddr=%0d done=%b, required 1/%0d/0",
                             k, eRfWe, eRfWaddr, eInitDone, expAddr);
                    failCount++;
                end
            end else if (k == 16) begin
                testCount++;
                if (eRfWe !== 1'b0 || eInitDone !== 1'b1) begin
                    $display("[TB] FAIL e_sweep_done: we=%b done=%b, required 0/1", eRfWe, eInitDone);
                    failCount++;
                end
            end
        end
        tick();
        testCount++;
        if (rfWe !== 1'b0 || initDone !== 1'b1) begin
            $display("[TB] FAIL sweep_done: we=%b done=%b, required 0/1", rfWe, initDone);
            failCount++;
        end
    endtask

    // Lone EX request: ready same cycle, write next cycle, then idle holds addr/data.
    task automatic test_single_ex();
        exValid = 1; exWaddr = 5'd5; exWdata = 32'hDEAD_BEEF;
        #1;
        testCount++;
        if (exReady !== 1'b1 || lsuReady !== 1'b0) begin
            $display("[TB] FAIL single_ex_ready: ex=%b lsu=%b, required 1/0", exReady, lsuReady);
            failCount++;
        end
        tick();
        exValid = 0;
        testCount++;
        if (rfWe !== 1'b1 || rfWaddr !== 5'd5 || rfWdata !== 32'hDEAD_BEEF) begin
            $display("[TB] FAIL single_ex_issue: we=%b waddr=%0d wdata=%h, required 1/5/deadbeef",
                     rfWe, rfWaddr, rfWdata);
            failCount++;
        end
        tick();
        testCount++;
        if (rfWe !== 1'b0 || rfWaddr !== 5'd5 || rfWdata !== 32'hDEAD_BEEF) begin
            $display("[TB] FAIL single_ex_idle: we=%b waddr=%0d wdata=%h, required 0/5/deadbeef",
                     rfWe, rfWaddr, rfWdata);
            failCount++;
        end
    endtask

    // Both requesters target x3; grants alternate EX, LSU, EX, LSU and LSU writes last.
    task automatic test_back_to_back();
        logic        exVTab   [4];
        logic [31:0] exDTab   [4];
        logic [31:0] lsuDTab  [4];
        logic        expExTab [4];
        logic [31:0] expDTab  [4];
        exVTab   = '{1'b1, 1'b1, 1'b1, 1'b0};
        exDTab   = '{32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0001, 32'h0};
        lsuDTab  = '{32'hBBBB_0000, 32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0001};
        expExTab = '{1'b1, 1'b0, 1'b1, 1'b0};
        expDTab  = '{32'hAAAA_0000, 32'hBBBB_0000, 32'hAAAA_0001, 32'hBBBB_0001};
        for (int i = 0; i < 4; i++) begin
            exValid = exVTab[i]; exWaddr = 5'd3; exWdata = exDTab[i];
            lsuValid = 1; lsuWaddr = 5'd3; lsuWdata = lsuDTab[i];
            #1;
            testCount++;
            if (exReady !== expExTab[i] || lsuReady !== !expExTab[i]) begin
                $display("[TB] FAIL rr_grant_%0d: ex=%b lsu=%b, required %b/%b",
                         i, exReady, lsuReady, expExTab[i], !expExTab[i]);
                failCount++;
            end
            tick();
            testCount++;
            if (rfWe !== 1'b1 || rfWaddr !== 5'd3 || rfWdata !== expDTab[i]) begin
                $display("[TB] FAIL rr_issue_%0d: we=%b waddr=%0d wdata=%h, required 1/3/%h",
                         i, rfWe, rfWaddr, rfWdata, expDTab[i]);
                failCount++;
            end
        end
        exValid = 0; lsuValid = 0;
        tick();
        testCount++;
        if (rfWe !== 1'b0 || rfWdata !== 32'hBBBB_0001) begin
            $display("[TB] FAIL rr_final: we=%b wdata=%h, required 0/bbbb0001", rfWe, rfWdata);
            failCount++;
        end
    endtask

    // Uncontended LSU grant left the pointer on LSU, so the next tie goes to LSU.
    task automatic test_pointer_hold();
        exValid = 1; exWaddr = 5'd8; exWdata = 32'h0000_0E08;
        lsuValid = 1; lsuWaddr = 5'd9; lsuWdata = 32'h0000_0F09;
        #1;
        testCount++;
        if (exReady !== 1'b0 || lsuReady !== 1'b1) begin
            $display("[TB] FAIL ptr_hold: ex=%b lsu=%b, required 0/1", exReady, lsuReady);
            failCount++;
        end
        tick();
        lsuValid = 0;
        #1;
        testCount++;
        if (exReady !== 1'b1 || rfWaddr !== 5'd9 || rfWdata !== 32'h0000_0F09) begin
            $display("[TB] FAIL ptr_hold_issue: exrdy=%b waddr=%0d wdata=%h, required 1/9/f09",
                     exReady, rfWaddr, rfWdata);
            failCount++;
        end
        tick();
        exValid = 0;
        testCount++;
        if (rfWe !== 1'b1 || rfWaddr !== 5'd8 || rfWdata !== 32'h0000_0E08) begin
            $display("[TB] FAIL ptr_hold_ex: we=%b waddr=%0d wdata=%h, required 1/8/e08",
                     rfWe, rfWaddr, rfWdata);
            failCount++;
        end
        tick();
    endtask

    // x0 writes complete the handshake without a write; a contended x0 grant still flips the pointer.
    task automatic test_x0();
        lsuValid = 1; lsuWaddr = 5'd0; lsuWdata = 32'h0000_1234;
        #1;
        testCount++;
        if (lsuReady !== 1'b1 || exReady !== 1'b0) begin
            $display("[TB] FAIL x0_ready: lsu=%b ex=%b, required 1/0", lsuReady, exReady);
            failCount++;
        end
        tick();
        lsuValid = 0;
        testCount++;
        if (rfWe !== 1'b0) begin
            $display("[TB] FAIL x0_no_write: we=%b, required 0", rfWe);
            failCount++;
        end
        // Pointer currently prefers EX: EX wins with x0, LSU loses and holds.
        exValid = 1; exWaddr = 5'd0; exWdata = 32'h0000_0000;
        lsuValid = 1; lsuWaddr = 5'd7; lsuWdata = 32'h0000_0077;
        #1;
        testCount++;
        if (exReady !== 1'b1 || lsuReady !== 1'b0) begin
            $display("[TB] FAIL x0_contend: ex=%b lsu=%b, required 1/0", exReady, lsuReady);
            failCount++;
        end
        tick();
        exWaddr = 5'd10; exWdata = 32'h0000_0099;
        #1;
        testCount++;
        if (rfWe !== 1'b0 || lsuReady !== 1'b1 || exReady !== 1'b0) begin
            $display("[TB] FAIL x0_ptr_flip: we=%b lsu=%b ex=%b, required 0/1/0", rfWe, lsuReady, exReady);
            failCount++;
        end
        tick();
        lsuValid = 0;
        testCount++;
        if (rfWe !== 1'b1 || rfWaddr !== 5'd7 || rfWdata !== 32'h0000_0077) begin
            $display("[TB] FAIL x0_loser_issue: we=%b waddr=%0d wdata=%h, required 1/7/77",
                     rfWe, rfWaddr, rfWdata);
            failCount++;
        end
        tick();
        exValid = 0;
        testCount++;
        if (rfWe !== 1'b1 || rfWaddr !== 5'd10 || rfWdata !== 32'h0000_0099) begin
            $display("[TB] FAIL x0_ex_issue: we=%b waddr=%0d wdata=%h, required 1/10/99",
                     rfWe, rfWaddr, rfWdata);
            failCount++;
        end
        tick();
    endtask

    // RV32E: upper address bit dropped for issue and for the x0 check.
    task automatic test_rv32e();
        eExValid = 1; eExWaddr = 5'h13; eExWdata = 32'h0000_0055;
        #1;
        testCount++;
        if (eExReady !== 1'b1) begin
            $display("[TB] FAIL e_ready: ex=%b, required 1", eExReady);
            failCount++;
        end
        tick();
        eExWaddr = 5'h10; eExWdata = 32'h0000_0066;
        testCount++;
        if (eRfWe !== 1'b1 || eRfWaddr !== 5'h03 || eRfWdata !== 32'h0000_0055) begin
            $display("[TB] FAIL e_issue: we=%b waddr=%h wdata=%h, required 1/03/55",
                     eRfWe, eRfWaddr, eRfWdata);
            failCount++;
        end
        tick();
        eExValid = 0;
        testCount++;
        if (eRfWe !== 1'b0) begin
            $display("[TB] FAIL e_x0_alias: we=%b, required 0", eRfWe);
            failCount++;
        end
        tick();
    endtask

    // Reset pulsed during the sweep: outputs clear at once, sweep restarts from 1.
    task automatic test_reset_midsweep();
        logic [4:0] expAddr;
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
        end
        testCount++;
        if (rfWe !== 1'b1 || rfWaddr !== 5'd10) begin
            $display("[TB] FAIL midsweep_pre: we=%b waddr=%0d, required 1/10", rfWe, rfWaddr);
            failCount++;
        end
        #2;
        rstN = 1'b0;
        #1;
        testCount++;
        if (rfWe !== 1'b0 || rfWaddr !== 5'd0 || rfWdata !== 32'd0 || initDone !== 1'b0) begin
            $display("[TB] FAIL midsweep_async: we=%b waddr=%0d wdata=%h done=%b, required all zero",
                     rfWe, rfWaddr, rfWdata, initDone);
            failCount++;
        end
        tick();
        tick();
        rstN = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            expAddr = 5'(k);
            testCount++;
            if (rfWe !== 1'b1 || rfWaddr !== expAddr || initDone !== 1'b0) begin
                $display("[TB] FAIL resweep_%0d: we=%b waddr=%0d done=%b, required 1/%0d/0",
                         k, rfWe, rfWaddr, initDone, expAddr);
                failCount++;
            end
        end
        tick();
        testCount++;
        if (rfWe !== 1'b0 || initDone !== 1'b1) begin
            $display("[TB] FAIL resweep_done: we=%b done=%b, required 0/1", rfWe, initDone);
            failCount++;
        end
    endtask

    initial begin
        test_reset();
        test_single_ex();
        test_back_to_back();
        test_pointer_hold();
        test_x0();
        test_rv32e();
        test_reset_midsweep();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ibex_rf_write_sched.md
Name: ibex_rf_write_sched

Overview:
- Write-port scheduler for the latch-based register file, which has a single write port (W1).
- Shares that port between two writeback requesters, EX (ALU/MUL result) and LSU (load data), using round-robin arbitration.
- Presents one registered write per cycle to the register file.
- After reset it can optionally sweep every architectural register to WordZeroVal before accepting any requester traffic.

Parameters:
- RV32E, 0, 1 = 16 registers (4-bit address used), 0 = 32 registers.
- DataWidth, 32, width of write data.
- InitSweep, 1, 1 = run the post-reset zeroing sweep; 0 = enter RUN directly.
- WordZeroVal, '0, value written by the sweep; also the reset value of rf_wdata_o.

Ports:
- clk_int  in  1  block clock.
- rst_ni  in  1  asynchronous, active-low reset.
- ex_valid_i  in  1  EX write request.
- ex_ready_o  out  1  EX request accepted this cycle.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  DataWidth  EX write data.
- lsu_valid_i  in  1  LSU write request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_waddr_i  in  5  LSU destination register.
- lsu_wdata_i  in  DataWidth  LSU write data.
- init_done_o  out  1  sweep complete; scheduler is in RUN.
- rf_we_o  out  1  to register file we_a_i.
- rf_waddr_o  out  5  to register file waddr_a_i.
- rf_wdata_o  out  DataWidth  to register file wdata_a_i.

Behaviour:
- Clock and reset are decided: reset rst_ni, asynchronous, active-low; clock clk_int.
- Reset values: rf_we_o=0, rf_waddr_o=0, rf_wdata_o=WordZeroVal, init_done_o=0 (1 if InitSweep=0), RR pointer=EX-preferred, sweep counter=1, state=INIT (RUN if InitSweep=0).
- FSM states: INIT, RUN. There is no exit from RUN except reset.
- INIT state:
  - Every cycle register rf_we_o=1, rf_waddr_o=cnt, rf_wdata_o=WordZeroVal.
  - cnt runs from 1 to NUM_WORDS-1, where NUM_WORDS = 2**(RV32E?4:5).
  - After issuing NUM_WORDS-1, go to RUN next cycle; init_done_o rises on that same edge.
  - Both readies are held at 0 throughout INIT.
  - Sweep length is exactly 31 cycles (15 when RV32E=1).
- RUN state:
  - Readies are combinational from the valids and the RR pointer.
  - Only one valid: that requester gets ready=1.
  - Both valid: the requester selected by the RR pointer gets ready=1, the other gets ready=0. After a contended grant the pointer flips to the loser.
  - Uncontended grants do not move the pointer.
  - Requesters hold valid/addr/data stable until ready (AXI-style); valid may not drop before acceptance.
- Issue (latency 1):
  - The accepted request is registered. The next cycle shows rf_we_o=1 with its addr and data.
  - No request accepted means rf_we_o=0 next cycle; rf_waddr_o/rf_wdata_o hold their previous values.
- x0 write:
  - An accepted request with waddr[ADDR_WIDTH-1:0]==0 completes its handshake.
  - It produces rf_we_o=0. The RR pointer still updates if the grant was contended.
- Address width:
  - When RV32E=1, upper bits of waddr are ignored for the x0 check.
  - rf_waddr_o is zero-extended from the low ADDR_WIDTH bits.
- Throughput: one write per cycle sustained. There is no internal buffering beyond the output register; backpressure goes to the losing requester only.
- Same destination from both requesters in one cycle: normal RR. The loser writes one cycle later, so its value is the final one.
- Reset asserted mid-sweep or mid-issue:
  - All outputs return immediately to their reset values, including rf_we_o=0 asynchronously.
  - The sweep restarts from register 1 after deassertion.
- Assertions (sim only):
  - Both readies never 1 together.
  - No ready during INIT.
  - valid stable until ready.

Decomposition:
- Shared package ibex_pkg gets two items:
  - rf_wsched_state_e {RF_WS_INIT, RF_WS_RUN}.
  - typedef rf_wreq_t {logic [4:0] waddr; logic [DataWidth-1:0] wdata;}, parameterised via a localparam width of 32.
- One sub-module: ibex_rr_arb2.
  - Contents: two-requester round-robin arbiter with its own pointer flop.
  - Ports: clk_int, rst_ni, req_i[1:0], gnt_o[1:0], advance_i.
- Sweep counter and output register stay in the top.

Test Plan:
- Reset with InitSweep=1, RV32E=0, no valids -> rf_we_o=1 on cycles 1..31 with rf_waddr_o 1..31 and data 0; init_done_o=1 at cycle 32; rf_we_o=0 afterwards.
- In RUN, ex_valid_i=1, addr 5, data 32'hDEAD_BEEF, lsu idle -> ex_ready_o=1 the same cycle; next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=32'hDEAD_BEEF.
- Both valid for 4 cycles (EX addr 3 data A, LSU addr 3 data B, each re-presenting new data after acceptance) -> grants alternate EX, LSU, EX, LSU; rf_we_o high for 4 consecutive cycles; last write to x3 is LSU's.
- LSU valid with addr 0, data 32'h1234 -> lsu_ready_o=1; the following cycle rf_we_o=0.
- rst_ni pulsed low at sweep cycle 10 -> rf_we_o=0 immediately; after release the sweep restarts at addr 1 and completes in 31 cycles.
- RV32E=1, EX addr 5'h13 -> issued with rf_waddr_o=5'h03; sweep covers 1..15 only; init_done_o at cycle 16.
